// File: rtl/stream_pkt_arbiter.sv
// Packet-level round-robin arbiter: shares one output stream between NUM_REQ lanes,
// holding each grant from sop to accepted eop and pushing the packet's compression flag at eop.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

module stream_pkt_arbiter #(
    parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_sop,
    input  logic [NUM_REQ-1:0]            s_eop,
    input  logic [NUM_REQ-1:0]            s_comp_flag,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_sop,
    output logic                          m_eop,
    output logic [ID_W-1:0]               m_src_id,
    input  logic                          m_ready,
    input  logic                          flag_full,
    output logic                          comp_flag,
    output logic                          comp_flag_valid,
    output logic                          err_sop
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_grant;
    logic [ID_W-1:0] r_last_grant;
    logic            r_flag;
    logic            r_first;
    logic            r_err;

    logic [NUM_REQ-1:0]    w_eligible;
    logic                  w_found;
    logic [ID_W-1:0]       w_winner;
    logic                  w_winner_flag;
    logic                  w_lane_valid;
    logic [DATA_WIDTH-1:0] w_lane_data;
    logic                  w_lane_sop;
    logic                  w_lane_eop;
    logic                  w_grant_now;
    logic                  w_push;
    logic                  w_err_set;

    assign w_eligible = s_valid & s_sop;

    // Scan last_grant+1, last_grant+2, ... and take the first eligible lane.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_found       = 1'b0;
        w_winner      = '0;
        w_winner_flag = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && w_eligible[j] && (j == (int'(r_last_grant) + k) % NUM_REQ)) begin
                    w_found       = 1'b1;
                    w_winner      = ID_W'(j);
                    w_winner_flag = s_comp_flag[j];
                end
            end
        end
    end

    always_comb begin
        w_lane_valid = 1'b0;
        w_lane_data  = '0;
        w_lane_sop   = 1'b0;
        w_lane_eop   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == r_grant) begin
                w_lane_valid = s_valid[i];
                w_lane_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_lane_sop   = s_sop[i];
                w_lane_eop   = s_eop[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_now = 1'b0;
        w_push      = 1'b0;
        w_err_set   = 1'b0;
        s_ready     = '0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_sop       = 1'b0;
        m_eop       = 1'b0;
        case (r_state)
            IDLE: begin
                w_err_set = |(s_valid & ~s_sop);
                if (w_found && !flag_full) begin
                    w_grant_now = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                m_valid = w_lane_valid;
                m_data  = w_lane_data;
                m_sop   = w_lane_sop;
                m_eop   = w_lane_eop;
                for (int i = 0; i < NUM_REQ; i++) begin
                    s_ready[i] = (ID_W'(i) == r_grant) && m_ready;
                end
                // A repeated sop after the first beat is flagged but still forwarded.
                w_err_set = w_lane_valid && w_lane_sop && !r_first;
                w_push    = w_lane_valid && m_ready && w_lane_eop;
                if (w_push) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_flag       <= 1'b0;
            r_first      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_now) begin
                r_grant <= w_winner;
                r_flag  <= w_winner_flag;
                r_first <= 1'b1;
            end else if (r_state == BUSY && w_lane_valid && m_ready) begin
                r_first <= 1'b0;
            end
            if (w_push) begin
                r_last_grant <= r_grant;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign m_src_id        = r_grant;
    assign comp_flag       = w_push ? r_flag : 1'b0;
    assign comp_flag_valid = w_push;
    assign err_sop         = r_err;

endmodule

// File: doc/stream_pkt_arbiter.md
# stream_pkt_arbiter

Packet-level round-robin arbiter that shares one compressed-output stream between `NUM_REQ` compressor lanes. It grants a lane at start-of-packet and holds the grant until that packet's end-of-packet beat is accepted. On that beat it pushes the lane's per-packet compression flag into the downstream flag FIFO, so flag order always matches packet order. It sits between the compressor lanes and the shared stream writer, and drives the writer-side flag FIFO's `comp_flag` / `comp_flag_valid` pair.

## Interface
- `DATA_WIDTH`, default `AXI_DATA_WIDTH`: stream beat width.
- `NUM_REQ`, default 4: number of requesting lanes; must be ≥2.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the source id.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_valid`  in  NUM_REQ  per-lane beat valid.
- `s_data`  in  NUM_REQ*DATA_WIDTH  per-lane beat data; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_sop`  in  NUM_REQ  per-lane first-beat marker.
- `s_eop`  in  NUM_REQ  per-lane last-beat marker.
- `s_comp_flag`  in  NUM_REQ  per-lane packet compression flag; valid together with that lane's sop beat.
- `s_ready`  out  NUM_REQ  per-lane accept.
- `m_valid`  out  1  output beat valid.
- `m_data`  out  DATA_WIDTH  output beat data.
- `m_sop`  out  1  output first-beat marker.
- `m_eop`  out  1  output last-beat marker.
- `m_src_id`  out  ID_W  lane currently granted.
- `m_ready`  in  1  downstream accept.
- `flag_full`  in  1  flag FIFO cannot take an entry.
- `comp_flag`  out  1  flag written to the flag FIFO.
- `comp_flag_valid`  out  1  one-cycle write strobe to the flag FIFO.
- `err_sop`  out  1  sticky protocol-error indication.

## Operation
- FSM states: IDLE and BUSY. Registers: `grant` (ID_W), `last_grant` (ID_W), `flag_q` (1).
- **Eligibility in IDLE:** lane i is eligible when `s_valid[i] & s_sop[i]`.
- **IDLE → BUSY:** taken when at least one lane is eligible and `flag_full` is 0.
  - Winner is the first eligible lane scanning `last_grant+1, last_grant+2, …` modulo NUM_REQ.
  - The winner is stored in `grant`; `s_comp_flag[winner]` is stored in `flag_q`.
  - If `flag_full` is 1, the FSM stays in IDLE.
- **Outputs in IDLE:**
  - `s_ready` is all zeros.
  - `m_valid`, `m_sop`, `m_eop` and `m_data` are 0.
  - `m_src_id` holds `grant`.
- **Outputs in BUSY** (combinational passthrough from lane g = `grant`):
  - `m_valid = s_valid[g]`, `m_data`, `m_sop`, `m_eop` come from lane g.
  - `s_ready[g] = m_ready`; all other `s_ready` bits are 0.
  - `m_src_id = g`.
- **BUSY → IDLE:** taken on the cycle where `m_valid & m_ready & m_eop`. On that same cycle:
  - `comp_flag = flag_q` and `comp_flag_valid = 1` for exactly one cycle.
  - `last_grant` is updated to `grant`.
- **No overflow check at eop:** `flag_full` was checked at grant time, and this block is the FIFO's only writer with at most one packet in flight. The push at eop therefore never overflows.
- **Single-beat packet** (sop and eop on the same beat): grant, then one BUSY cycle, then the push.
- **`err_sop` sets on either violation; it is cleared only by reset:**
  - In IDLE, a lane has `s_valid` high with `s_sop` low. That lane is not eligible and stalls.
  - In BUSY, the granted lane presents `s_sop` on a beat after its first beat. The beat is still forwarded unchanged.
- **Reset values:**
  - State IDLE; `last_grant = NUM_REQ-1`, so lane 0 has first priority.
  - `grant = 0`, `flag_q = 0`.
  - All outputs 0: `s_ready`, `m_*`, `comp_flag`, `comp_flag_valid`, `err_sop`.
- **Reset mid-packet:** the packet is abandoned, no flag is pushed, and arbitration restarts from lane 0.

## Timing
- Arbitration latency is one cycle: the first eligible cycle registers the grant, and the earliest first-beat transfer is the next cycle.
- Back-to-back packets: the eop transfer cycle is followed by one IDLE arbitration cycle. Minimum output spacing is therefore packet length plus one cycle.
- Within a packet there is zero added latency and full throughput. `m_ready` backpressure propagates combinationally to `s_ready[g]`.
- `comp_flag_valid` is asserted in the same cycle as the accepted eop beat.
- `flag_full` is sampled only in IDLE.
- Fairness: a continuously requesting lane waits at most NUM_REQ-1 packets.

## Test plan
- **Single lane:** lane 2 sends a 3-beat packet with `s_comp_flag=1` and `m_ready` held at 1.
  - Grant lands on the cycle after sop is seen.
  - Three beats appear on `m_*` with `m_src_id=2`.
  - `comp_flag_valid` pulses once with `comp_flag=1`, aligned with the eop beat.
- **Round-robin:** all 4 lanes request continuously with 1-beat packets, starting from reset.
  - Grant order is 0,1,2,3,0,…
  - There is exactly one IDLE cycle between packets.
  - Flags are emitted in the same order.
- **Backpressure:** toggle `m_ready` 1,0,0,1 during a 4-beat packet from lane 1.
  - No beat is lost or duplicated.
  - `s_ready[1]` mirrors `m_ready`; all other lanes see `s_ready=0` throughout.
- **Flag FIFO full:** hold `flag_full=1` for 5 cycles while lane 0 requests.
  - No grant is made and `s_ready` stays 0.
  - The grant occurs on the first cycle `flag_full=0`.
- **Protocol errors:** lane 3 raises `s_valid` without sop while IDLE.
  - `err_sop` goes to 1 and stays 1.
  - Lane 3 is never granted.
  - Other lanes are still served.
- **Reset mid-packet:** assert `rst` after beat 2 of a 5-beat packet.
  - All outputs go to 0 immediately.
  - No `comp_flag_valid` is emitted.
  - After release, a lane-0 request is granted first.
